mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// RISC-V RV32I memory-access stage, directly upstream of the MEM/WB pipeline
// register. Takes EX-stage results, performs LB/LH/LW/LBU/LHU/SB/SH/SW through a
// req/ready data-memory port with lane alignment and sign extension, passes
// non-memory ops through, and drives data/store_reg/rd/opcode into MEM/WB.
// PARAMETERS
// TIMEOUT  16  max cycles in ACCESS before abort with fault (>=2)
// PORTS
// clk            in   1   clock, rising edge
// rst_n          in   1   asynchronous active-low reset
// valid_in       in   1   EX presents an instruction this cycle
// alu_result_in  in   32  ALU result; byte address for load/store
// store_data_in  in   32  rs2 value for stores
// funct3_in      in   3   width/sign select
// opcode_in      in   7   instruction opcode
// rd_in          in   5   destination register
// store_reg_in   in   1   instruction writes rd
// stall_out      out  1   hold upstream; high exactly while state==ACCESS
// dmem_req       out  1   memory request, high in ACCESS
// dmem_we        out  1   1=store, 0=load (valid with req)
// dmem_addr      out  32  {addr[31:2],2'b00}
// dmem_be        out  4   byte-lane enables (store); 0 for load
// dmem_wdata     out  32  lane-replicated store data
// dmem_ready     in   1   memory completes request, sampled in ACCESS only
// dmem_rdata     in   32  load word, valid with dmem_ready
// valid_out      out  1   one-cycle pulse: result presented to MEM/WB
// data_out       out  32  writeback value
// store_reg_out  out  1   write rd; forced 0 when valid_out=0 or fault_out=1
// rd_out         out  5   destination register
// opcode_out     out  7   opcode of retiring instruction
// fault_out      out  1   with valid_out: misalign, bad funct3 or timeout
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, all outputs 0, counter 0; an
//   outstanding request is dropped (dmem_req falls immediately).
// - FSM IDLE/ACCESS. Accept only in IDLE with valid_in=1, at the rising edge.
// - Non-memory opcode: next edge valid_out=1, data_out=alu_result_in,
//   store_reg_out=store_reg_in, rd/opcode copied. Latency 1, no stall.
// - LOAD 0000011 / STORE 0100011: latch addr, funct3, rs2, rd, opcode, goto ACCESS.
//   Fault check at accept: LH/LHU/SH addr[0]!=0, LW/SW addr[1:0]!=0, load funct3
//   in {3,6,7}, store funct3>=3 -> no ACCESS; next edge valid_out=1, fault_out=1,
//   store_reg_out=0, data_out=0.
// - ACCESS: dmem_req=1 from registers; counter increments each cycle. Edge with
//   dmem_ready=1 -> IDLE, valid_out=1. Minimum mem latency 2 cycles.
// - Counter reaches TIMEOUT-1 without ready -> IDLE, valid_out=1, fault_out=1,
//   store_reg_out=0. Ready in the same edge as timeout wins (normal completion).
// - Store: SB be=1<<a[1:0], wdata={4{rs2[7:0]}}; SH be=a[1]?1100:0011,
//   wdata={2{rs2[15:0]}}; SW be=1111. Result: data_out=0, store_reg_out=0.
// - Load lane: byte = rdata[8*a[1:0]+:8], half = rdata[16*a[1]+:16]; LB/LH
//   sign-extend, LBU/LHU zero-extend, LW full word; store_reg_out=store_reg_in.
// - stall_out=1 throughout ACCESS, so upstream holds its next instruction; that
//   instruction is accepted at the first IDLE edge (back-to-back capable).
// - valid_in ignored in ACCESS; dmem_ready/dmem_rdata ignored in IDLE.
// - Cycles without a result: valid_out=0, store_reg_out=0, fault_out=0;
//   data_out/rd_out/opcode_out hold last values.
// TESTING
// - ADD alu=0x1234, rd=5, store_reg=1 -> next edge valid_out=1, data_out=0x1234,
//   rd_out=5, stall_out never high.
// - LB addr=0x103, rdata=0x80FF_FF_FF, ready after 3 cycles -> dmem_addr=0x100,
//   stall 3 cycles, data_out=0xFFFFFF80; LBU same -> 0x00000080.
// - SH addr=0x102 rs2=0xABCD1234 -> be=1100, wdata=0x12341234, we=1,
//   store_reg_out=0.
// - LW addr=0x101 -> no dmem_req, valid_out=1, fault_out=1, store_reg_out=0.
// - LW with dmem_ready stuck 0 -> abort after TIMEOUT cycles in ACCESS,
//   fault_out=1; following ADD accepted next edge.
// - rst_n low during ACCESS -> dmem_req, stall_out, valid_out 0 immediately,
//   IDLE after release; late ready ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// RV32I memory-access stage: aligns loads and stores onto a req/ready data port
// and presents exactly one result per instruction to the MEM/WB register.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [2:0]  funct3_in,
  input  logic [6:0]  opcode_in,
  input  logic [4:0]  rd_in,
  input  logic        store_reg_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [31:0] data_out,
  output logic        store_reg_out,
  output logic [4:0]  rd_out,
  output logic [6:0]  opcode_out,
  output logic        fault_out
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int         CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [29:0]   word_addr_q;
  logic [1:0]    lane_q;
  logic [2:0]    funct3_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic          store_reg_q;
  logic [4:0]    rd_q;
  logic [6:0]    opcode_q;

  logic        is_mem, misalign, bad_f3, fault_acc;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  assign stall_out  = (state == ACCESS);
  assign dmem_req   = stall_out;
  assign dmem_we    = stall_out & we_q;
  assign dmem_addr  = stall_out ? {word_addr_q, 2'b00} : 32'h0;
  assign dmem_be    = stall_out ? be_q : 4'h0;
  assign dmem_wdata = stall_out ? wdata_q : 32'h0;

  // Accept-time decode: alignment / funct3 legality and store lane placement.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    is_mem     = (opcode_in == OP_LOAD) || (opcode_in == OP_STORE);
    misalign   = 1'b0;
    bad_f3     = 1'b0;
    be_next    = 4'h0;
    wdata_next = 32'h0;
    case (funct3_in[1:0])
      2'd1:    misalign = alu_result_in[0];
      2'd2:    misalign = |alu_result_in[1:0];
      default: misalign = 1'b0;
    endcase
    if (opcode_in == OP_STORE) begin
      bad_f3 = (funct3_in >= 3'd3);
      case (funct3_in[1:0])
        2'd0: begin
          be_next    = 4'b0001 << alu_result_in[1:0];
          wdata_next = {4{store_data_in[7:0]}};
        end
        2'd1: begin
          be_next    = alu_result_in[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{store_data_in[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = store_data_in;
        end
      endcase
    end else begin
      bad_f3 = (funct3_in == 3'd3) || (funct3_in == 3'd6) || (funct3_in == 3'd7);
    end
  end

  assign fault_acc = is_mem && (misalign || bad_f3);

  always_comb begin
    lane_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
    lane_half = dmem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'd0:    load_data = {{24{lane_byte[7]}}, lane_byte};
      3'd1:    load_data = {{16{lane_half[15]}}, lane_half};
      3'd4:    load_data = {24'h0, lane_byte};
      3'd5:    load_data = {16'h0, lane_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      word_addr_q   <= '0;
      lane_q        <= '0;
      funct3_q      <= '0;
      we_q          <= 1'b0;
      be_q          <= '0;
      wdata_q       <= '0;
      store_reg_q   <= 1'b0;
      rd_q          <= '0;
      opcode_q      <= '0;
      valid_out     <= 1'b0;
      data_out      <= '0;
      store_reg_out <= 1'b0;
      rd_out        <= '0;
      opcode_out    <= '0;
      fault_out     <= 1'b0;
    end else begin
      valid_out     <= 1'b0;
      store_reg_out <= 1'b0;
      fault_out     <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (!is_mem) begin
              valid_out     <= 1'b1;
              data_out      <= alu_result_in;
              store_reg_out <= store_reg_in;
              rd_out        <= rd_in;
              opcode_out    <= opcode_in;
            end else if (fault_acc) begin
              valid_out  <= 1'b1;
              fault_out  <= 1'b1;
              data_out   <= '0;
              rd_out     <= rd_in;
              opcode_out <= opcode_in;
            end else begin
              state       <= ACCESS;
              cnt         <= '0;
              word_addr_q <= alu_result_in[31:2];
              lane_q      <= alu_result_in[1:0];
              funct3_q    <= funct3_in;
              we_q        <= (opcode_in == OP_STORE);
              be_q        <= be_next;
              wdata_q     <= wdata_next;
              store_reg_q <= store_reg_in;
              rd_q        <= rd_in;
              opcode_q    <= opcode_in;
            end
          end
        end
        ACCESS: begin
          // A ready on the final counted cycle still completes normally.
          if (dmem_ready) begin
            state         <= IDLE;
            valid_out     <= 1'b1;
            data_out      <= we_q ? 32'h0 : load_data;
            store_reg_out <= !we_q && store_reg_q;
            rd_out        <= rd_q;
            opcode_out    <= opcode_q;
          end else if (cnt == CNT_LAST) begin
            state      <= IDLE;
            valid_out  <= 1'b1;
            fault_out  <= 1'b1;
            data_out   <= '0;
            rd_out     <= rd_q;
            opcode_out <= opcode_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a transaction-level model predicts each
// result and access window; a per-cycle compare process checks the DUT against it.
module tb_mem_access_unit;
  localparam int         TIMEOUT  = 16;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] alu_result_in = '0;
  logic [31:0] store_data_in = '0;
  logic [2:0]  funct3_in = '0;
  logic [6:0]  opcode_in = '0;
  logic [4:0]  rd_in = '0;
  logic        store_reg_in = 1'b0;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall_out, dmem_req, dmem_we, valid_out, store_reg_out, fault_out;
  logic [31:0] dmem_addr, dmem_wdata, data_out;
  logic [3:0]  dmem_be;
  logic [4:0]  rd_out;
  logic [6:0]  opcode_out;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .funct3_in(funct3_in), .opcode_in(opcode_in),
    .rd_in(rd_in), .store_reg_in(store_reg_in), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .valid_out(valid_out), .data_out(data_out), .store_reg_out(store_reg_out),
    .rd_out(rd_out), .opcode_out(opcode_out), .fault_out(fault_out)
  );

  typedef struct {
    logic [31:0] data;
    bit          data_known;
    logic        store_reg;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic        fault;
    int          due;
  } result_t;

  result_t     exp_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          acc_lo = 1;
  int          acc_hi = 0;
  int          stall_cnt = 0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_be = '0;
  logic [31:0] last_data = '0;
  bit          last_known = 1'b1;
  logic [4:0]  last_rd = '0;
  logic [6:0]  last_op = '0;
  logic [31:0] seen_addr = '0, seen_wdata = '0;
  logic [3:0]  seen_be = '0;
  logic        seen_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    result_t r;
    if (!rst_n) begin
      check("rst_valid", valid_out, 0);
      check("rst_req", dmem_req, 0);
      check("rst_stall", stall_out, 0);
      check("rst_data", data_out, 0);
      check("rst_rd", rd_out, 0);
      check("rst_opcode", opcode_out, 0);
      check("rst_fault", fault_out, 0);
      check("rst_store_reg", store_reg_out, 0);
      last_data = '0; last_known = 1'b1; last_rd = '0; last_op = '0;
    end else begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        r = exp_q.pop_front();
        check("res_valid", valid_out, 1);
        check("res_fault", fault_out, r.fault);
        check("res_store_reg", store_reg_out, r.store_reg);
        check("res_rd", rd_out, r.rd);
        check("res_opcode", opcode_out, r.opcode);
        if (r.data_known) check("res_data", data_out, r.data);
        last_data = r.data; last_known = r.data_known; last_rd = r.rd; last_op = r.opcode;
      end else begin
        check("idle_valid", valid_out, 0);
        check("idle_store_reg", store_reg_out, 0);
        check("idle_fault", fault_out, 0);
        check("hold_rd", rd_out, last_rd);
        check("hold_opcode", opcode_out, last_op);
        if (last_known) check("hold_data", data_out, last_data);
      end
      if (cyc >= acc_lo && cyc <= acc_hi) begin
        check("acc_stall", stall_out, 1);
        check("acc_req", dmem_req, 1);
        check("acc_we", dmem_we, exp_we);
        check("acc_addr", dmem_addr, exp_addr);
        check("acc_be", dmem_be, exp_be);
        if (exp_we) check("acc_wdata", dmem_wdata, exp_wdata);
      end else begin
        check("no_stall", stall_out, 0);
        check("no_req", dmem_req, 0);
      end
      if (stall_out) stall_cnt++;
    end
  end

  // Model one instruction from the ISA rules, then drive it and the memory side.
  // delay = ACCESS cycle in which ready rises (0 = never).
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic sr,
                       input logic [31:0] rdata, input int delay);
    result_t     r;
    bit          is_load, is_store, legal, acc, in_time;
    int          size, c, lat;
    logic [31:0] v;
    is_load  = (op == OP_LOAD);
    is_store = (op == OP_STORE);
    size     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal    = is_load ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
    in_time  = (delay >= 1) && (delay <= TIMEOUT);
    c   = cyc;
    lat = 1;
    acc = 1'b0;
    r.rd = rd; r.opcode = op; r.fault = 1'b0; r.data_known = 1'b1;
    r.data = addr; r.store_reg = sr;
    if (is_load || is_store) begin
      if (!legal || (int'(addr[1:0]) % size) != 0) begin
        r.fault = 1'b1; r.store_reg = 1'b0; r.data = '0;
      end else begin
        acc      = 1'b1;
        lat      = in_time ? delay + 1 : TIMEOUT + 1;
        exp_addr = {addr[31:2], 2'b00};
        exp_we   = is_store;
        if (is_store) begin
          exp_be    = (f3 == 3'd0) ? (4'b0001 << addr[1:0]) :
                      (f3 == 3'd1) ? (4'b0011 << addr[1:0]) : 4'hF;
          exp_wdata = (f3 == 3'd0) ? 32'(rs2[7:0]) * 32'h0101_0101 :
                      (f3 == 3'd1) ? 32'(rs2[15:0]) * 32'h0001_0001 : rs2;
          r.data = '0; r.store_reg = 1'b0;
        end else begin
          exp_be = 4'h0;
          v = rdata >> (8 * int'(addr[1:0]));
          case (f3)
            3'd0: begin v = v & 32'hFF;   if (v[7])  v = v | 32'hFFFF_FF00; end
            3'd1: begin v = v & 32'hFFFF; if (v[15]) v = v | 32'hFFFF_0000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = rdata;
          endcase
          r.data = v;
        end
        if (!in_time) begin
          r.fault = 1'b1; r.store_reg = 1'b0; r.data_known = 1'b0;
        end
        acc_lo = c + 1;
        acc_hi = c + lat - 1;
      end
    end
    r.due = c + lat;
    exp_q.push_back(r);

    valid_in = 1'b1; opcode_in = op; funct3_in = f3; alu_result_in = addr;
    store_data_in = rs2; rd_in = rd; store_reg_in = sr;
    @(posedge clk); #1;
    valid_in = 1'b0;
    if (acc) begin
      seen_addr = dmem_addr; seen_be = dmem_be; seen_wdata = dmem_wdata; seen_we = dmem_we;
      // Upstream keeps presenting a follower while stalled; it must be ignored.
      valid_in = 1'b1; opcode_in = OP_ADD; rd_in = 5'd31;
      alu_result_in = 32'hDEAD_BEEF; store_reg_in = 1'b1;
      for (int k = 1; k <= TIMEOUT; k++) begin
        dmem_ready = (delay >= 1) && (k >= delay);
        dmem_rdata = dmem_ready ? rdata : $urandom();
        @(posedge clk); #1;
        if (dmem_ready) break;
      end
      dmem_ready = 1'b0;
      valid_in   = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", valid_out, 0);
    check("post_rst_data", data_out, 0);

    issue(OP_ADD, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 32'h0, 0);
    check("add_valid", valid_out, 1);
    check("add_data", data_out, 32'h0000_1234);
    check("add_rd", rd_out, 5);

    stall_cnt = 0;
    issue(OP_LOAD, 3'd0, 32'h0000_0103, 32'h0, 5'd6, 1'b1, 32'h80FF_FFFF, 3);
    check("lb_stall_cycles", stall_cnt, 3);
    check("lb_addr", seen_addr, 32'h0000_0100);
    check("lb_data", data_out, 32'hFFFF_FF80);
    issue(OP_LOAD, 3'd4, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 32'h80FF_FFFF, 3);
    check("lbu_data", data_out, 32'h0000_0080);

    issue(OP_STORE, 3'd1, 32'h0000_0102, 32'hABCD_1234, 5'd0, 1'b0, 32'h0, 2);
    check("sh_be", seen_be, 4'b1100);
    check("sh_wdata", seen_wdata, 32'h1234_1234);
    check("sh_we", seen_we, 1);
    check("sh_store_reg", store_reg_out, 0);

    issue(OP_LOAD, 3'd2, 32'h0000_0101, 32'h0, 5'd8, 1'b1, 32'h0, 2);
    check("lw_mis_fault", fault_out, 1);
    check("lw_mis_store_reg", store_reg_out, 0);

    issue(OP_LOAD, 3'd1, 32'h0000_0102, 32'h0, 5'd9, 1'b1, 32'h8001_7FFF, 2);
    check("lh_data", data_out, 32'hFFFF_8001);
    issue(OP_LOAD, 3'd5, 32'h0000_0100, 32'h0, 5'd10, 1'b1, 32'h8001_F00D, 2);
    issue(OP_LOAD, 3'd2, 32'h0000_0104, 32'h0, 5'd11, 1'b1, 32'hCAFE_BABE, 5);
    issue(OP_LOAD, 3'd0, 32'h0000_0201, 32'h0, 5'd12, 1'b0, 32'h0000_7F00, 2);
    issue(OP_STORE, 3'd0, 32'h0000_0101, 32'h0000_0055, 5'd0, 1'b0, 32'h0, 2);
    check("sb_be", seen_be, 4'b0010);
    issue(OP_STORE, 3'd2, 32'h0000_0108, 32'h0123_4567, 5'd0, 1'b0, 32'h0, 4);
    issue(OP_LUI, 3'd0, 32'h1234_5000, 32'h0, 5'd13, 1'b1, 32'h0, 0);

    issue(OP_LOAD, 3'd3, 32'h0000_0100, 32'h0, 5'd14, 1'b1, 32'h0, 2);
    issue(OP_STORE, 3'd3, 32'h0000_0100, 32'h0, 5'd0, 1'b0, 32'h0, 2);
    issue(OP_LOAD, 3'd5, 32'h0000_0203, 32'h0, 5'd15, 1'b1, 32'h0, 2);
    issue(OP_STORE, 3'd1, 32'h0000_0101, 32'h0, 5'd0, 1'b0, 32'h0, 2);
    issue(OP_STORE, 3'd2, 32'h0000_0106, 32'h0, 5'd0, 1'b0, 32'h0, 2);

    issue(OP_LOAD, 3'd2, 32'h0000_0300, 32'h0, 5'd16, 1'b1, 32'h1357_9BDF, TIMEOUT);
    check("ready_at_last_fault", fault_out, 0);
    stall_cnt = 0;
    issue(OP_LOAD, 3'd2, 32'h0000_0304, 32'h0, 5'd17, 1'b1, 32'h0, 0);
    check("timeout_stall_cycles", stall_cnt, TIMEOUT);
    check("timeout_fault", fault_out, 1);
    issue(OP_ADD, 3'd0, 32'h0000_0042, 32'h0, 5'd18, 1'b1, 32'h0, 0);
    check("add_after_timeout", data_out, 32'h0000_0042);

    // Reset while a load is outstanding.
    acc_lo = cyc + 1; acc_hi = cyc + 1000;
    exp_addr = 32'h0000_0200; exp_we = 1'b0; exp_be = 4'h0;
    valid_in = 1'b1; opcode_in = OP_LOAD; funct3_in = 3'd2;
    alu_result_in = 32'h0000_0200; rd_in = 5'd19; store_reg_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    acc_lo = 1; acc_hi = 0;
    exp_q.delete();
    #1;
    check("rst_mid_req", dmem_req, 0);
    check("rst_mid_stall", stall_out, 0);
    check("rst_mid_valid", valid_out, 0);
    dmem_ready = 1'b1; dmem_rdata = 32'h5A5A_5A5A;
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    dmem_ready = 1'b0;
    issue(OP_ADD, 3'd0, 32'h0000_0777, 32'h0, 5'd20, 1'b1, 32'h0, 0);
    check("add_after_reset", data_out, 32'h0000_0777);

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
